// File: rtl/hovalaag_pkg.sv
// Shared constants and types for the Hovalaag CPU input path.
// Word widths are fixed by the CPU; the FIFO depth is the default only.
package hovalaag_pkg;

  localparam int CPU_W         = 12;
  localparam int WORD_W        = CPU_W;
  localparam int DEFAULT_DEPTH = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    CH1 = 1'b0,
    CH2 = 1'b1
  } chan_e;

endpackage

// File: rtl/hovalaag_fifo_chan.sv
// One first-word-fall-through input channel: storage, pointers, occupancy
// and a sticky underflow flag for reads attempted while empty.
module hovalaag_fifo_chan
  import hovalaag_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  word_t                    push_data,
  input  logic                     pop_req,
  output word_t                    head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  word_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign do_push = push && (level != FULL_LVL);
  assign do_pop  = pop_req && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      underflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      level <= level + LVL_W'(1);
      else if (do_pop && !do_push) level <= level - LVL_W'(1);
      if (pop_req && empty) underflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; clearing pointers and level is
  // enough to discard contents, and leaves the array mappable to RAM.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= push_data;
  end

  // Head falls through combinationally; an empty channel presents zero.
  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/hovalaag_in_fifo.sv
// Two independent host-to-CPU input FIFOs feeding the IN1/IN2 ports;
// the host picks a channel per word with wr_sel.
module hovalaag_in_fifo
  import hovalaag_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_W-1:0]      wr_data,
  input  logic                   wr_sel,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [WORD_W-1:0]      IN1,
  input  logic                   IN1_adv,
  output logic [WORD_W-1:0]      IN2,
  input  logic                   IN2_adv,
  output logic [$clog2(DEPTH):0] level1,
  output logic [$clog2(DEPTH):0] level2,
  output logic [1:0]             underflow
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  chan_e sel;
  logic  push1;
  logic  push2;

  assign sel = chan_e'(wr_sel);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    wr_ready = 1'b0;
    push1    = 1'b0;
    push2    = 1'b0;
    case (sel)
      CH1: begin
        wr_ready = (level1 != FULL_LVL);
        push1    = wr_valid && wr_ready;
      end
      CH2: begin
        wr_ready = (level2 != FULL_LVL);
        push2    = wr_valid && wr_ready;
      end
      default: ;
    endcase
  end

  hovalaag_fifo_chan #(.DEPTH(DEPTH)) u_chan1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_data (wr_data),
    .pop_req   (IN1_adv),
    .head      (IN1),
    .level     (level1),
    .underflow (underflow[0])
  );

  hovalaag_fifo_chan #(.DEPTH(DEPTH)) u_chan2 (
    .clk       (clk),
    .rst       (rst),
    .push      (push2),
    .push_data (wr_data),
    .pop_req   (IN2_adv),
    .head      (IN2),
    .level     (level2),
    .underflow (underflow[1])
  );

endmodule

// File: tb/tb_hovalaag_in_fifo.sv
// Scoreboard bench for hovalaag_in_fifo: per-channel queues hold expected
// words; heads are compared when popped, levels/flags after every edge.
module tb_hovalaag_in_fifo;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [11:0]   wr_data;
  logic          wr_sel;
  logic          wr_valid;
  logic          wr_ready;
  logic [11:0]   IN1;
  logic          IN1_adv;
  logic [11:0]   IN2;
  logic          IN2_adv;
  logic [LW-1:0] level1;
  logic [LW-1:0] level2;
  logic [1:0]    underflow;

  logic [11:0] q1[$];
  logic [11:0] q2[$];
  logic [1:0]  exp_uf;
  int          n_total = 0;
  int          n_pass  = 0;

  always #5 clk = ~clk;

  hovalaag_in_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_data   (wr_data),
    .wr_sel    (wr_sel),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .IN1       (IN1),
    .IN1_adv   (IN1_adv),
    .IN2       (IN2),
    .IN2_adv   (IN2_adv),
    .level1    (level1),
    .level2    (level2),
    .underflow (underflow)
  );

  // One clock of stimulus; the model is updated from pre-edge state, then
  // all observable outputs are compared against it #1 after the edge.
  task automatic drive_cycle(input logic v, input logic sel, input logic [11:0] d,
                             input logic a1, input logic a2);
    logic        exp_rdy;
    logic [11:0] e;
    wr_valid = v; wr_sel = sel; wr_data = d; IN1_adv = a1; IN2_adv = a2;
    #1;
    exp_rdy = sel ? (q2.size() < DEPTH) : (q1.size() < DEPTH);
    n_total++;
    if (wr_ready !== exp_rdy) $display("FAIL wr_ready: got %b expected %b", wr_ready, exp_rdy);
    else n_pass++;
    if (a1) begin
      if (q1.size() > 0) begin
        e = q1.pop_front();
        n_total++;
        if (IN1 !== e) $display("FAIL pop IN1: got %h expected %h", IN1, e);
        else n_pass++;
      end else exp_uf[0] = 1'b1;
    end
    if (a2) begin
      if (q2.size() > 0) begin
        e = q2.pop_front();
        n_total++;
        if (IN2 !== e) $display("FAIL pop IN2: got %h expected %h", IN2, e);
        else n_pass++;
      end else exp_uf[1] = 1'b1;
    end
    if (v && exp_rdy) begin
      if (sel) q2.push_back(d);
      else     q1.push_back(d);
    end
    @(posedge clk); #1;
    wr_valid = 1'b0; IN1_adv = 1'b0; IN2_adv = 1'b0;
    n_total++;
    if (int'(level1) !== q1.size()) $display("FAIL level1: got %0d expected %0d", level1, q1.size());
    else n_pass++;
    n_total++;
    if (int'(level2) !== q2.size()) $display("FAIL level2: got %0d expected %0d", level2, q2.size());
    else n_pass++;
    e = (q1.size() > 0) ? q1[0] : 12'h000;
    n_total++;
    if (IN1 !== e) $display("FAIL head IN1: got %h expected %h", IN1, e);
    else n_pass++;
    e = (q2.size() > 0) ? q2[0] : 12'h000;
    n_total++;
    if (IN2 !== e) $display("FAIL head IN2: got %h expected %h", IN2, e);
    else n_pass++;
    n_total++;
    if (underflow !== exp_uf) $display("FAIL underflow: got %b expected %b", underflow, exp_uf);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b0; wr_sel = 1'b0; wr_data = '0; IN1_adv = 1'b0; IN2_adv = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q1.delete(); q2.delete(); exp_uf = 2'b00;
    #1;
    n_total++;
    if ({IN1, IN2} !== 24'h0) $display("FAIL reset IN: got %h/%h expected 000/000", IN1, IN2);
    else n_pass++;
    n_total++;
    if (wr_ready !== 1'b1) $display("FAIL reset wr_ready: got %b expected 1", wr_ready);
    else n_pass++;
    n_total++;
    if ({level1, level2, underflow} !== '0)
      $display("FAIL reset state: got %0d/%0d/%b expected 0/0/00", level1, level2, underflow);
    else n_pass++;
  endtask

  task automatic test_ch1_basic();
    drive_cycle(1'b1, 1'b0, 12'h123, 1'b0, 1'b0);
    n_total++;
    if (IN1 !== 12'h123) $display("FAIL basic first: got %h expected 123", IN1);
    else n_pass++;
    drive_cycle(1'b1, 1'b0, 12'h456, 1'b0, 1'b0);
    n_total++;
    if (level1 !== LW'(2)) $display("FAIL basic level: got %0d expected 2", level1);
    else n_pass++;
    drive_cycle(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    n_total++;
    if (IN1 !== 12'h456 || level1 !== LW'(1))
      $display("FAIL basic adv: got %h/%0d expected 456/1", IN1, level1);
    else n_pass++;
    drive_cycle(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
  endtask

  task automatic test_ch2_full();
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 1'b1, 12'(i), 1'b0, 1'b0);
    wr_sel = 1'b1; #1;
    n_total++;
    if (wr_ready !== 1'b0) $display("FAIL full ready sel1: got %b expected 0", wr_ready);
    else n_pass++;
    wr_sel = 1'b0; #1;
    n_total++;
    if (wr_ready !== 1'b1) $display("FAIL full ready sel0: got %b expected 1", wr_ready);
    else n_pass++;
    drive_cycle(1'b1, 1'b1, 12'hFFF, 1'b0, 1'b0);
    n_total++;
    if (level2 !== LW'(16)) $display("FAIL full drop: got %0d expected 16", level2);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      n_total++;
      if (IN2 !== 12'(i)) $display("FAIL drain order: got %h expected %h", IN2, 12'(i));
      else n_pass++;
      // First pop also offers a push: a full channel must not accept it.
      drive_cycle(i == 0, 1'b1, 12'hEEE, 1'b0, 1'b1);
    end
    n_total++;
    if (IN2 !== 12'h000 || level2 !== '0)
      $display("FAIL drained: got %h/%0d expected 000/0", IN2, level2);
    else n_pass++;
  endtask

  task automatic test_underflow();
    drive_cycle(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
    n_total++;
    if (underflow !== 2'b01 || level1 !== '0)
      $display("FAIL underflow set: got %b/%0d expected 01/0", underflow, level1);
    else n_pass++;
    repeat (2) drive_cycle(1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
    n_total++;
    if (underflow !== 2'b01) $display("FAIL underflow sticky: got %b expected 01", underflow);
    else n_pass++;
    drive_cycle(1'b1, 1'b0, 12'h0AB, 1'b1, 1'b0);
    n_total++;
    if (IN1 !== 12'h0AB || level1 !== LW'(1))
      $display("FAIL push on empty adv: got %h/%0d expected 0ab/1", IN1, level1);
    else n_pass++;
    drive_cycle(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 12'h200 + 12'(i), 1'b0, 1'b0);
    for (int i = 3; i < 40; i++) begin
      drive_cycle(1'b1, 1'b0, 12'h200 + 12'(i), 1'b1, 1'b0);
      n_total++;
      if (level1 !== LW'(3)) $display("FAIL wrap level: got %0d expected 3", level1);
      else n_pass++;
    end
    n_total++;
    if (IN1 !== 12'h225) $display("FAIL wrap head: got %h expected 225", IN1);
    else n_pass++;
    repeat (3) drive_cycle(1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
  endtask

  task automatic test_simul_pop();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b0, 12'hA00 + 12'(i), 1'b0, 1'b0);
      drive_cycle(1'b1, 1'b1, 12'hB00 + 12'(i), 1'b0, 1'b0);
    end
    drive_cycle(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
    n_total++;
    if (IN1 !== 12'hA01 || IN2 !== 12'hB01)
      $display("FAIL dual adv: got %h/%h expected a01/b01", IN1, IN2);
    else n_pass++;
    repeat (2) drive_cycle(1'b0, 1'b0, 12'h000, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 1'b0, 12'hC00 + 12'(i), 1'b0, 1'b0);
      drive_cycle(1'b1, 1'b1, 12'hD00 + 12'(i), 1'b0, 1'b0);
    end
    rst = 1'b1; wr_valid = 1'b1; wr_sel = 1'b0; wr_data = 12'h999; IN1_adv = 1'b1; IN2_adv = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wr_valid = 1'b0; IN1_adv = 1'b0; IN2_adv = 1'b0;
    q1.delete(); q2.delete(); exp_uf = 2'b00;
    n_total++;
    if (level1 !== '0 || level2 !== '0)
      $display("FAIL mid reset level: got %0d/%0d expected 0/0", level1, level2);
    else n_pass++;
    n_total++;
    if (IN1 !== 12'h000 || IN2 !== 12'h000)
      $display("FAIL mid reset IN: got %h/%h expected 000/000", IN1, IN2);
    else n_pass++;
    n_total++;
    if (underflow !== 2'b00) $display("FAIL mid reset underflow: got %b expected 00", underflow);
    else n_pass++;
    drive_cycle(1'b1, 1'b0, 12'h777, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ch1_basic();
    test_ch2_full();
    test_underflow();
    test_wrap();
    test_simul_pop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hovalaag_in_fifo.md
HOVALAAG_IN_FIFO -- requirements
Module: hovalaag_in_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, giving entries per channel; must be a power of 2, minimum 2.
REQ-002 SHALL have port clk, input, 1 bit: clock, all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port wr_data, input, 12 bits: host word to enqueue.
REQ-005 SHALL have port wr_sel, input, 1 bit: target channel, 0 = channel 1, 1 = channel 2.
REQ-006 SHALL have port wr_valid, input, 1 bit: host offers wr_data.
REQ-007 SHALL have port wr_ready, output, 1 bit: selected channel can accept a word.
REQ-008 SHALL have port IN1, output, 12 bits: head word of channel 1, to the CPU IN1 input.
REQ-009 SHALL have port IN1_adv, input, 1 bit: CPU consumed IN1 this cycle.
REQ-010 SHALL have port IN2, output, 12 bits: head word of channel 2, to the CPU IN2 input.
REQ-011 SHALL have port IN2_adv, input, 1 bit: CPU consumed IN2 this cycle.
REQ-012 SHALL have port level1, output, clog2(DEPTH)+1 bits: channel 1 occupancy.
REQ-013 SHALL have port level2, output, clog2(DEPTH)+1 bits: channel 2 occupancy.
REQ-014 SHALL have port underflow, output, 2 bits: sticky flags; bit0 = channel 1, bit1 = channel 2.

Function
REQ-015 SHALL be first-word-fall-through: INn = entry at channel n read pointer, combinationally, whenever leveln > 0.
REQ-016 SHALL drive INn = 12'h000 whenever leveln == 0.
REQ-017 SHALL drive wr_ready = (level of the channel selected by wr_sel) < DEPTH, combinational from wr_sel and level registers only.
REQ-018 SHALL accept a push on the rising edge when wr_valid & wr_ready: store wr_data at the selected channel write pointer, advance the pointer, increment the level.
REQ-019 SHALL pop channel n on the rising edge when INn_adv & (leveln > 0): advance the read pointer, decrement the level; the next word appears on INn in the following cycle.
REQ-020 SHALL, on INn_adv while leveln == 0, leave channel n pointers and level unchanged and set underflow[n-1].
REQ-021 SHALL, on a push and a valid pop to the same channel in one cycle, advance both pointers and leave the level unchanged.
REQ-022 SHALL, on a push to an empty channel coincident with INn_adv, flag underflow and store the word with no bypass; the word is visible on INn the next cycle.
REQ-023 SHALL, when a channel is full, hold wr_ready low even if a pop occurs in the same cycle (no full-bypass).
REQ-024 SHALL wrap pointers modulo DEPTH; pointer width is clog2(DEPTH).
REQ-025 SHALL treat the two channels independently; IN1_adv and IN2_adv both high is legal, and each is handled per REQ-019/020.
REQ-026 SHALL clear underflow bits only by rst.
REQ-027 SHALL have zero-cycle latency from the head entry to INn, and one cycle from push to visibility on an empty channel.

Reset
REQ-028 SHALL, when rst is high at a clock edge, clear all pointers, level1, level2 and underflow to 0, and ignore push/pop that cycle.
REQ-029 SHALL, after reset, output IN1 = IN2 = 12'h000 and wr_ready = 1.
REQ-030 SHALL, on reset mid-operation, discard queued contents; storage arrays are not cleared.

Structure
REQ-031 SHALL take WORD_W = 12 and the default DEPTH = 16 from shared package hovalaag_pkg, alongside the CPU word-width constant.
REQ-032 SHALL instantiate sub-module hovalaag_fifo_chan twice, one per channel; it holds storage, pointers, level, FWFT read, push/pop and underflow-detect, parameterised by DEPTH.
REQ-033 SHALL keep wr_sel demultiplexing and wr_ready muxing in the top level.

Verification
REQ-034 SHALL cover reset, then push 12'h123, 12'h456 to channel 1 -> IN1 = 123 one cycle after the first push, level1 = 2; IN1_adv for 1 cycle -> IN1 = 456, level1 = 1.
REQ-035 SHALL cover filling channel 2 with 16 words 0..15 -> wr_ready = 0 with wr_sel = 1 and still 1 with wr_sel = 0; a push attempt is dropped; 16 pops return 0..15 in order, then IN2 = 0 and level2 = 0.
REQ-036 SHALL cover pulsing IN1_adv on an empty channel 1 -> underflow = 2'b01, level1 stays 0, sticky until rst.
REQ-037 SHALL cover level1 = 3 with a simultaneous push and IN1_adv -> level1 = 3, head advances, order preserved across pointer wrap (push 40 words total through a depth-16 channel).
REQ-038 SHALL cover rst asserted with both channels holding 5 words -> next cycle level1 = level2 = 0, IN1 = IN2 = 000, underflow = 00.
REQ-039 SHALL cover simultaneous IN1_adv and IN2_adv with both channels non-empty -> both heads advance in the same cycle.
